// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset core: sequences IF/ID/EX/MEM/WB,
// handshakes with instruction/data memories and counts retired instructions.
module mips_multicycle_ctrl #(
    parameter int CNT_W    = 32,
    parameter int LINK_REG = 31
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      instr,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             alu_zero,
    output logic [31:0]      ir,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             alu_src_imm,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    // The datapath turns reg_dst=10 into this register index.
    if (LINK_REG < 0 || LINK_REG > 31) begin : g_bad_link
        $error("LINK_REG must be a valid register index");
    end

    // Held as a raw encoding so illegal values 5-7 stay representable.
    logic [2:0]       state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [5:0] op;
    logic       is_r, is_j, is_jal, is_br, is_ld, is_st;
    logic       retire;

    assign op     = ir_q[31:26];
    assign is_r   = (op == 6'b000000);
    assign is_j   = (op[5:1] == 5'b00001);
    assign is_jal = (op == 6'b000011);
    assign is_br  = (op == 6'b000100) || (op == 6'b000101);
    assign is_ld  = (op[5:3] == 3'b100);
    assign is_st  = (op[5:3] == 3'b101);

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        retired_d   = retired_q;
        retire      = 1'b0;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 2'b00;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        reg_dst     = 2'b00;
        mem_to_reg  = 1'b0;

        case (state_q)
            S_IF: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = instr;
                    pc_we   = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                if (is_j) begin
                    pc_we   = 1'b1;
                    pc_sel  = 2'b10;
                    retire  = 1'b1;
                    state_d = S_IF;
                    if (is_jal) begin
                        reg_we  = 1'b1;
                        reg_dst = 2'b10;
                    end
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                alu_src_imm = !is_r && !is_br;
                if (is_br) begin
                    // op[0] distinguishes BNE from BEQ
                    if (op[0] ? !alu_zero : alu_zero) begin
                        pc_we  = 1'b1;
                        pc_sel = 2'b01;
                    end
                    retire  = 1'b1;
                    state_d = S_IF;
                end else if (is_ld || is_st) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = op[3];
                if (dmem_ack) begin
                    if (is_st) begin
                        retire  = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                reg_dst    = is_r ? 2'b00 : 2'b01;
                mem_to_reg = is_ld;
                retire     = 1'b1;
                state_d    = S_IF;
            end
            default: state_d = S_IF;
        endcase

        if (retire) retired_d = retired_q + CNT_W'(1);

        // Requests and strobes drop in the very cycle reset is sampled.
        if (rst) begin
            imem_req    = 1'b0;
            dmem_req    = 1'b0;
            dmem_we     = 1'b0;
            pc_we       = 1'b0;
            pc_sel      = 2'b00;
            alu_src_imm = 1'b0;
            reg_we      = 1'b0;
            reg_dst     = 2'b00;
            mem_to_reg  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IF;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign ir      = ir_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class
// through the FSM and checks strobes, state sequence and retire count.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack;
    logic [31:0] instr;
    logic        dmem_req, dmem_we, dmem_ack;
    logic        alu_zero;
    logic [31:0] ir;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        alu_src_imm, reg_we, mem_to_reg;
    logic [1:0]  reg_dst;
    logic [2:0]  state;
    logic [31:0] retired;

    int tests = 0;
    int fails = 0;

    mips_multicycle_ctrl #(.CNT_W(32), .LINK_REG(31)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .alu_zero(alu_zero), .ir(ir), .pc_we(pc_we), .pc_sel(pc_sel),
        .alu_src_imm(alu_src_imm), .reg_we(reg_we), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge, then settle before checks.
    task automatic cyc(input logic ia, input logic [31:0] in, input logic da, input logic az);
        @(negedge clk);
        imem_ack = ia;
        instr    = in;
        dmem_ack = da;
        alu_zero = az;
        #1;
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; instr = '0; dmem_ack = 1'b0; alu_zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_imem_req", 32'(imem_req), 0);
        chk("rst_ir", ir, 0);
        chk("rst_retired", retired, 0);
        rst = 1'b0;

        // R-type 0x00000000: IF ID EX WB
        cyc(1, 32'h0000_0000, 0, 0);
        chk("r_if_state", 32'(state), 0);
        chk("r_if_imem_req", 32'(imem_req), 1);
        chk("r_if_pc_we", 32'(pc_we), 1);
        chk("r_if_pc_sel", 32'(pc_sel), 0);
        cyc(0, 32'hFFFF_FFFF, 0, 0);
        chk("r_id_state", 32'(state), 1);
        chk("r_id_pc_we", 32'(pc_we), 0);
        cyc(0, 0, 0, 0);
        chk("r_ex_state", 32'(state), 2);
        chk("r_ex_alu_src_imm", 32'(alu_src_imm), 0);
        cyc(0, 0, 0, 0);
        chk("r_wb_state", 32'(state), 4);
        chk("r_wb_reg_we", 32'(reg_we), 1);
        chk("r_wb_reg_dst", 32'(reg_dst), 0);
        chk("r_wb_mem_to_reg", 32'(mem_to_reg), 0);
        cyc(0, 0, 0, 0);
        chk("r_done_state", 32'(state), 0);
        chk("r_done_retired", retired, 1);
        chk("if_wait_pc_we", 32'(pc_we), 0);
        chk("if_wait_imem_req", 32'(imem_req), 1);

        // ADDI
        cyc(1, 32'h2000_0000, 0, 0);
        cyc(0, 0, 0, 0);
        chk("addi_ir", ir, 32'h2000_0000);
        cyc(0, 0, 0, 0);
        chk("addi_ex_alu_src_imm", 32'(alu_src_imm), 1);
        cyc(0, 0, 0, 0);
        chk("addi_wb_state", 32'(state), 4);
        chk("addi_wb_reg_dst", 32'(reg_dst), 1);
        chk("addi_wb_reg_we", 32'(reg_we), 1);

        // LW with two dmem wait cycles
        cyc(1, 32'h8C00_0000, 0, 0);
        chk("lw_if_retired", retired, 2);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("lw_ex_alu_src_imm", 32'(alu_src_imm), 1);
        cyc(0, 0, 0, 0);
        chk("lw_mem1_state", 32'(state), 3);
        chk("lw_mem1_dmem_req", 32'(dmem_req), 1);
        chk("lw_mem1_dmem_we", 32'(dmem_we), 0);
        cyc(0, 0, 0, 0);
        chk("lw_mem2_state", 32'(state), 3);
        cyc(0, 0, 1, 0);
        chk("lw_mem3_state", 32'(state), 3);
        chk("lw_mem3_dmem_req", 32'(dmem_req), 1);
        cyc(0, 0, 0, 0);
        chk("lw_wb_state", 32'(state), 4);
        chk("lw_wb_mem_to_reg", 32'(mem_to_reg), 1);
        chk("lw_wb_reg_dst", 32'(reg_dst), 1);

        // SW
        cyc(1, 32'hAC00_0000, 0, 0);
        chk("sw_if_retired", retired, 3);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        chk("sw_mem_dmem_req", 32'(dmem_req), 1);
        chk("sw_mem_dmem_we", 32'(dmem_we), 1);
        chk("sw_mem_reg_we", 32'(reg_we), 0);
        cyc(0, 0, 0, 0);
        chk("sw_done_state", 32'(state), 0);
        chk("sw_done_reg_we", 32'(reg_we), 0);
        chk("sw_done_retired", retired, 4);

        // BEQ taken
        cyc(1, 32'h1000_0000, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk("beq_t_state", 32'(state), 2);
        chk("beq_t_pc_we", 32'(pc_we), 1);
        chk("beq_t_pc_sel", 32'(pc_sel), 1);
        chk("beq_t_alu_src_imm", 32'(alu_src_imm), 0);
        // BEQ not taken
        cyc(1, 32'h1000_0000, 0, 0);
        chk("beq_t_retired", retired, 5);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("beq_nt_pc_we", 32'(pc_we), 0);
        // BNE taken
        cyc(1, 32'h1400_0000, 0, 0);
        chk("beq_nt_retired", retired, 6);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("bne_t_pc_we", 32'(pc_we), 1);
        chk("bne_t_pc_sel", 32'(pc_sel), 1);

        // J and JAL
        cyc(1, 32'h0800_0000, 0, 0);
        chk("bne_retired", retired, 7);
        cyc(0, 0, 1, 0);
        chk("j_id_state", 32'(state), 1);
        chk("j_id_pc_we", 32'(pc_we), 1);
        chk("j_id_pc_sel", 32'(pc_sel), 2);
        chk("j_id_reg_we", 32'(reg_we), 0);
        chk("j_stray_dmem_req", 32'(dmem_req), 0);
        cyc(1, 32'h0C00_0000, 0, 0);
        chk("j_done_state", 32'(state), 0);
        chk("j_done_retired", retired, 8);
        cyc(0, 0, 0, 0);
        chk("jal_id_pc_sel", 32'(pc_sel), 2);
        chk("jal_id_reg_we", 32'(reg_we), 1);
        chk("jal_id_reg_dst", 32'(reg_dst), 2);
        cyc(0, 0, 0, 0);
        chk("jal_done_state", 32'(state), 0);
        chk("jal_done_retired", retired, 9);

        // Reset in MEM with dmem_req high
        cyc(1, 32'h8C00_0000, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("rstmem_dmem_req", 32'(dmem_req), 1);
        rst = 1'b1; #1;
        chk("rstmem_req_drop", 32'(dmem_req), 0);
        cyc(0, 0, 0, 0);
        chk("rstmem_state", 32'(state), 0);
        chk("rstmem_retired", retired, 0);
        chk("rstmem_ir", ir, 0);
        rst = 1'b0;

        // Illegal encoding recovers to IF
        @(negedge clk);
        force dut.state_q = 3'd6;
        #1;
        chk("illegal_state", 32'(state), 6);
        release dut.state_q;
        cyc(0, 0, 0, 0);
        chk("illegal_recover", 32'(state), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the MIPS-subset core.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Classifies opcode instr[31:26] as R (000000), J (00001x) or I (everything else), with I sub-classed into load, store, branch and ALU-immediate.
- Drives instruction/data memory request handshakes and datapath enables, and keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- LINK_REG, 31, register index written by JAL.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request, held until imem_ack.
- imem_ack  in  1  fetch complete; instr valid this cycle.
- instr  in  32  fetched instruction word.
- dmem_req  out  1  data memory request, held until dmem_ack.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req.
- dmem_ack  in  1  data access complete.
- alu_zero  in  1  ALU zero flag, sampled in EX.
- ir  out  32  latched instruction register.
- pc_we  out  1  PC write enable, one-cycle pulse.
- pc_sel  out  2  00 PC+4, 01 branch target, 10 jump target.
- alu_src_imm  out  1  ALU operand B = sign-extended immediate.
- reg_we  out  1  register-file write enable, one-cycle pulse.
- reg_dst  out  2  00 rd, 01 rt, 10 LINK_REG.
- mem_to_reg  out  1  writeback data from memory.
- state  out  3  current state encoding.
- retired  out  CNT_W  completed-instruction count.

Behaviour:
- States: IF=0, ID=1, EX=2, MEM=3, WB=4. Encodings 5-7 are illegal and go to IF next cycle.
- Reset: state=IF; ir=0; retired=0; all strobes, requests, pc_sel, reg_dst, alu_src_imm, mem_to_reg = 0. imem_req rises the first cycle after rst deasserts.
- Reset mid-operation: reset wins over every event. Outstanding requests drop in the same cycle reset is sampled. No retire count.
- IF:
  - imem_req=1 until imem_ack.
  - On the ack cycle: ir<=instr, pc_we=1, pc_sel=00, go ID.
  - Without ack, stay in IF; all outputs except imem_req are 0.
- ID (1 cycle):
  - J-class: pc_we=1, pc_sel=10, go IF, retire.
  - JAL (000011) additionally asserts reg_we=1, reg_dst=10 in the same cycle.
  - Other classes: go EX.
- EX (1 cycle); alu_src_imm=1 for all I-class except branch.
  - Branch (000100 BEQ, 000101 BNE): taken when alu_zero (BEQ) or !alu_zero (BNE). If taken, pc_we=1, pc_sel=01. Go IF, retire.
  - Load (100xxx) and store (101xxx): go MEM.
  - R and ALU-immediate: go WB.
- MEM:
  - dmem_req=1 and dmem_we=opcode[29] until dmem_ack.
  - Store: on ack go IF, retire.
  - Load: on ack go WB.
- WB (1 cycle):
  - reg_we=1.
  - reg_dst=00 for R, 01 for I.
  - mem_to_reg=1 for load only.
  - Go IF, retire.
- Retire: retired increments by 1 on the cycle the FSM leaves for IF with an instruction completed. It wraps modulo 2^CNT_W.
- Latency with zero-wait memories (IF entry to next IF):
  - J: 2 cycles.
  - Branch: 3 cycles.
  - R / ALU-immediate: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Wait states: each wait cycle on imem_ack or dmem_ack adds exactly 1 cycle. No timeout.
- Ack without request: an ack arriving while the matching request is low is ignored.
- Strobes: pc_we and reg_we never stay high for more than one cycle per state visit.

Test Plan:
- Reset, then instr=0x00000000 with imem_ack in the first IF cycle -> states 0,1,2,4,0. reg_we=1, reg_dst=00 in cycle 4. retired=1.
- ADDI 0x20000000, then LW 0x8C000000 with dmem_ack delayed 2 cycles:
  - ADDI -> WB with reg_dst=01.
  - LW -> MEM held 3 cycles, dmem_we=0, then WB with mem_to_reg=1.
  - retired=2.
- SW 0xAC000000 -> dmem_req with dmem_we=1. Returns to IF on ack with no reg_we pulse.
- BEQ 0x10000000:
  - alu_zero=1 -> EX pulses pc_we=1, pc_sel=01.
  - Repeat with alu_zero=0 -> no pc_we in EX.
  - BNE 0x14000000 with alu_zero=0 -> taken.
- J 0x08000000 -> ID pulses pc_we with pc_sel=10 and no reg_we. JAL 0x0C000000 -> ID also pulses reg_we with reg_dst=10. Each completes in 2 cycles.
- Assert rst while in MEM with dmem_req high -> next cycle state=0, dmem_req=0, retired=0. Force state to 6 -> next state 0.
